// File: rtl/encoder_speed_if.sv
// Period-in / speed-out bundle between the encoder period reader and the control/display logic.
interface encoder_speed_if #(
    parameter int PERIOD_W = 32,
    parameter int SPEED_W  = 16
);
    logic [PERIOD_W-1:0] period;
    logic                period_valid;
    logic [SPEED_W-1:0]  speed;
    logic                speed_valid;
    logic                busy;
    logic                stalled;
    logic                overrun;

    modport master (
        output period, period_valid,
        input  speed, speed_valid, busy, stalled, overrun
    );
    modport slave (
        input  period, period_valid,
        output speed, speed_valid, busy, stalled, overrun
    );
endinterface

// File: rtl/encoder_speed.sv
// Period-to-speed converter: speed = SCALE / period through a bit-serial restoring divider, with a
// one-deep pending buffer and a stall timeout. Macro ENC_SPEED_AVG_EN divides by a 4-sample average.
module encoder_speed #(
    parameter int PERIOD_W     = 32,
    parameter int SPEED_W      = 16,
    parameter int SCALE        = 50_000_000,
    parameter int STALL_CYCLES = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    encoder_speed_if.slave bus
);
    localparam int CNT_W   = $clog2(PERIOD_W);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0]    LAST_BIT  = CNT_W'(PERIOD_W - 1);
    localparam logic [STALL_W-1:0]  STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0]  STALL_PRE = STALL_W'(STALL_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] SCALE_V   = PERIOD_W'(SCALE);
    localparam logic [PERIOD_W-1:0] SPEED_MAX = PERIOD_W'({SPEED_W{1'b1}});

    typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] rem_q, rem_d;
    logic [PERIOD_W-1:0] dvd_q, dvd_d;
    logic [PERIOD_W-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                pend_full_q, pend_full_d;
    logic [PERIOD_W-1:0] pend_q, pend_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic                speed_valid_q, speed_valid_d;
    logic                busy_q, busy_d;
    logic                stalled_q, stalled_d;
    logic                overrun_q, overrun_d;
    logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic [PERIOD_W-1:0] sample;
    logic [PERIOD_W-1:0] divisor_load;
    logic [PERIOD_W:0]   rem_shift;
    logic                q_bit;

    // A fresh strobe beats a buffered sample: the newest measurement is the one worth converting.
    assign sample = bus.period_valid ? bus.period : pend_q;

`ifdef ENC_SPEED_AVG_EN
    logic [PERIOD_W-1:0] win_q [4];
    logic [PERIOD_W-1:0] win_d [4];
    logic                win_fresh_q, win_fresh_d;
    logic                take_en;
    logic [PERIOD_W+1:0] win_sum;

    assign take_en = (state_q == S_IDLE) && (bus.period_valid || pend_full_q);

    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        if (gi == 0) begin : g_head
            assign win_d[gi] = sample;
        end else begin : g_tail
            assign win_d[gi] = win_fresh_q ? sample : win_q[gi-1];
        end
    end

    assign win_sum = {2'b00, win_d[0]} + {2'b00, win_d[1]} + {2'b00, win_d[2]} + {2'b00, win_d[3]};
    assign divisor_load = PERIOD_W'(win_sum >> 2);
    // A stall is the only cycle where stalled rises; after it the window must be refilled from scratch.
    assign win_fresh_d = (stalled_d && !stalled_q) ? 1'b1 : (take_en ? 1'b0 : win_fresh_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            win_fresh_q <= 1'b1;
            for (int i = 0; i < 4; i++) win_q[i] <= '0;
        end else begin
            win_fresh_q <= win_fresh_d;
            if (take_en) win_q <= win_d;
        end
    end
`else
    assign divisor_load = sample;
`endif

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        dvd_d         = dvd_q;
        divisor_d     = divisor_q;
        bit_cnt_d     = bit_cnt_q;
        pend_full_d   = pend_full_q;
        pend_d        = pend_q;
        speed_d       = speed_q;
        speed_valid_d = 1'b0;
        stalled_d     = stalled_q;
        overrun_d     = overrun_q;
        stall_cnt_d   = stall_cnt_q;
        rem_shift     = {rem_q, dvd_q[PERIOD_W-1]};
        q_bit         = 1'b0;

        if (bus.period_valid) begin
            stall_cnt_d = '0;
            stalled_d   = 1'b0;
        end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
            if (stall_cnt_q == STALL_PRE) begin
                stalled_d     = 1'b1;
                speed_d       = '0;
                speed_valid_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (bus.period_valid || pend_full_q) begin
                    pend_full_d = 1'b0;
                    // The buffered sample is discarded unserved, which counts as an overrun.
                    if (bus.period_valid && pend_full_q) overrun_d = 1'b1;
                    if (divisor_load == '0) begin
                        dvd_d   = '1;
                        state_d = S_DONE;
                    end else begin
                        rem_d     = '0;
                        dvd_d     = SCALE_V;
                        divisor_d = divisor_load;
                        bit_cnt_d = '0;
                        state_d   = S_DIV;
                    end
                end
            end
            S_DIV: begin
                q_bit = (rem_shift >= {1'b0, divisor_q});
                rem_d = q_bit ? (rem_shift[PERIOD_W-1:0] - divisor_q) : rem_shift[PERIOD_W-1:0];
                dvd_d = {dvd_q[PERIOD_W-2:0], q_bit};
                if (bit_cnt_q == LAST_BIT) state_d = S_DONE;
                else bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                speed_d       = (dvd_q > SPEED_MAX) ? '1 : dvd_q[SPEED_W-1:0];
                speed_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && bus.period_valid) begin
            if (pend_full_q) overrun_d = 1'b1;
            pend_full_d = 1'b1;
            pend_d      = bus.period;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            rem_q         <= '0;
            dvd_q         <= '0;
            divisor_q     <= '0;
            bit_cnt_q     <= '0;
            pend_full_q   <= 1'b0;
            pend_q        <= '0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            stalled_q     <= 1'b0;
            overrun_q     <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            dvd_q         <= dvd_d;
            divisor_q     <= divisor_d;
            bit_cnt_q     <= bit_cnt_d;
            pend_full_q   <= pend_full_d;
            pend_q        <= pend_d;
            speed_q       <= speed_d;
            speed_valid_q <= speed_valid_d;
            busy_q        <= busy_d;
            stalled_q     <= stalled_d;
            overrun_q     <= overrun_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign bus.speed       = speed_q;
    assign bus.speed_valid = speed_valid_q;
    assign bus.busy        = busy_q;
    assign bus.stalled     = stalled_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_encoder_speed.sv
// Bench for encoder_speed: vector table, directed corner sequences, then random traffic vs a transaction model.
module tb_encoder_speed;
    localparam int  PW      = 32;
    localparam int  SW      = 16;
    localparam int  SCALE_M = 1000;
    localparam int  SCALE_S = 1_000_000;
    localparam int  STALL   = 100;

    logic          clk;
    logic          reset;
    logic [PW-1:0] period;
    logic          pv;

    int n_cmp  = 0;
    int n_fail = 0;

    encoder_speed_if #(.PERIOD_W(PW), .SPEED_W(SW)) bus_m ();
    encoder_speed_if #(.PERIOD_W(PW), .SPEED_W(SW)) bus_s ();

    assign bus_m.period       = period;
    assign bus_m.period_valid = pv;
    assign bus_s.period       = period;
    assign bus_s.period_valid = pv;

    encoder_speed #(.PERIOD_W(PW), .SPEED_W(SW), .SCALE(SCALE_M), .STALL_CYCLES(STALL)) dut (
        .clk(clk), .reset(reset), .bus(bus_m)
    );
    encoder_speed #(.PERIOD_W(PW), .SPEED_W(SW), .SCALE(SCALE_S), .STALL_CYCLES(1_000_000)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; pv = 1'b0;
        @(negedge clk); reset = 1'b0;
        check("reset_speed",   bus_m.speed, 0);
        check("reset_sv",      bus_m.speed_valid, 0);
        check("reset_busy",    bus_m.busy, 0);
        check("reset_stalled", bus_m.stalled, 0);
        check("reset_overrun", bus_m.overrun, 0);
    endtask

    task automatic pulse(input logic [PW-1:0] p);
        @(negedge clk); period = p; pv = 1'b1;
        @(negedge clk); pv = 1'b0;
    endtask

    task automatic wait_sv(output int n);
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!bus_m.speed_valid && n < 200);
        if (!bus_m.speed_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL speed_valid_timeout: got no pulse in %0d cycles, required a pulse", n);
        end
    endtask

    task automatic quiet(input int cycles, output int nsv, output int nbusy);
        nsv = 0; nbusy = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_m.speed_valid) nsv++;
            if (bus_m.busy) nbusy++;
        end
    endtask

    // Transaction-level reference: each accepted sample is a job finishing at a known edge with SCALE/divisor.
    int unsigned    m_edge, m_done_edge;
    bit             m_job, m_pend_full, m_stalled, m_overrun, m_sv;
    logic [PW-1:0]  m_pend;
    longint         m_result;
    int             m_cnt;
    logic [SW-1:0]  m_speed;
    longint         m_win [4];
    bit             m_fresh;

    task automatic model_reset();
        m_edge = 0; m_done_edge = 0; m_job = 0; m_pend_full = 0; m_pend = '0;
        m_stalled = 0; m_overrun = 0; m_sv = 0; m_result = 0; m_cnt = 0; m_speed = '0;
        m_fresh = 1;
        for (int i = 0; i < 4; i++) m_win[i] = 0;
    endtask

    task automatic model_step(input bit in_pv, input logic [PW-1:0] p);
        bit     idle, stall_now;
        longint s, div;
        m_edge++;
        idle = !m_job;
        m_sv = 0; stall_now = 0;
        if (in_pv) begin
            m_cnt = 0; m_stalled = 0;
        end else if (m_cnt < STALL) begin
            m_cnt++;
            if (m_cnt == STALL) begin stall_now = 1; m_stalled = 1; m_speed = '0; m_sv = 1; end
        end
        if (m_job && m_edge == m_done_edge) begin
            m_speed = (m_result > 65535) ? 16'hFFFF : m_result[15:0];
            m_sv = 1; m_job = 0;
        end
        if (idle && (in_pv || m_pend_full)) begin
            s = in_pv ? longint'(p) : longint'(m_pend);
            if (in_pv && m_pend_full) m_overrun = 1;
            m_pend_full = 0;
`ifdef ENC_SPEED_AVG_EN
            if (m_fresh) begin
                for (int i = 0; i < 4; i++) m_win[i] = s;
            end else begin
                m_win[3] = m_win[2]; m_win[2] = m_win[1]; m_win[1] = m_win[0]; m_win[0] = s;
            end
            m_fresh = 0;
            div = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
`else
            div = s;
`endif
            if (div == 0) begin m_result = 64'hFFFF_FFFF; m_done_edge = m_edge + 1; end
            else begin m_result = SCALE_M / div; m_done_edge = m_edge + PW + 1; end
            m_job = 1;
        end else if (!idle && in_pv) begin
            if (m_pend_full) m_overrun = 1;
            m_pend = p; m_pend_full = 1;
        end
        if (stall_now) m_fresh = 1;
    endtask

    typedef struct {
        logic [PW-1:0] period;
        logic [SW-1:0] exp_main;
        logic [SW-1:0] exp_sat;
        int            exp_lat;
    } vec_t;

    vec_t vecs [9];
    int   rates [8];

    initial begin
        int n, nsv, nbusy, exp2;
        reset = 1'b1; pv = 1'b0; period = '0;

        vecs[0] = '{32'd10,         16'd100,    16'hFFFF, 33};
        vecs[1] = '{32'd0,          16'hFFFF,   16'hFFFF, 1};
        vecs[2] = '{32'd5,          16'd200,    16'hFFFF, 33};
        vecs[3] = '{32'd16,         16'd62,     16'd62500, 33};
        vecs[4] = '{32'd15,         16'd66,     16'hFFFF, 33};
        vecs[5] = '{32'd1000,       16'd1,      16'd1000, 33};
        vecs[6] = '{32'd2000,       16'd0,      16'd500,  33};
        vecs[7] = '{32'd3,          16'd333,    16'hFFFF, 33};
        vecs[8] = '{32'hFFFF_FFFF,  16'd0,      16'd0,    33};

        for (int i = 0; i < 9; i++) begin
            do_reset();
            pulse(vecs[i].period);
            check("busy_after_capture", bus_m.busy, 1);
            wait_sv(n);
            check("latency", n, vecs[i].exp_lat);
            check("speed_main", bus_m.speed, vecs[i].exp_main);
            check("sv_sat", bus_s.speed_valid, 1);
            check("speed_sat", bus_s.speed, vecs[i].exp_sat);
            @(negedge clk);
            check("sv_one_cycle", bus_m.speed_valid, 0);
            check("busy_after_done", bus_m.busy, 0);
            $display("vector %0d: period=%0d speed=%0d sat_speed=%0d latency=%0d", i, vecs[i].period,
                     bus_m.speed, bus_s.speed, n);
        end

        // Two samples arrive while busy: the later one wins and overrun latches.
        do_reset();
        pulse(32'd10);
        repeat (3) @(negedge clk);
        pulse(32'd20);
        check("overrun_single_pending", bus_m.overrun, 0);
        repeat (3) @(negedge clk);
        pulse(32'd50);
        check("overrun_set", bus_m.overrun, 1);
        wait_sv(n);
        check("first_speed", bus_m.speed, 100);
`ifdef ENC_SPEED_AVG_EN
        exp2 = 50;
`else
        exp2 = 20;
`endif
        wait_sv(n);
        check("pending_gap", n, PW + 2);
        check("pending_speed", bus_m.speed, exp2);
        quiet(5, nsv, nbusy);
        check("no_third_result", nsv, 0);
        check("overrun_sticky", bus_m.overrun, 1);
        $display("overrun seq: second speed=%0d gap=%0d", bus_m.speed, n);

        // Stall timeout and recovery.
        do_reset();
        pulse(32'd10);
        wait_sv(n);
        check("pre_stall_speed", bus_m.speed, 100);
        wait_sv(n);
        check("stall_delay", n, STALL - PW - 1);
        check("stall_flag", bus_m.stalled, 1);
        check("stall_speed", bus_m.speed, 0);
        quiet(60, nsv, nbusy);
        check("stall_no_repulse", nsv, 0);
        check("stall_held", bus_m.stalled, 1);
        pulse(32'd4);
        check("stall_cleared", bus_m.stalled, 0);
        check("speed_zero_until_done", bus_m.speed, 0);
        wait_sv(n);
        check("post_stall_speed", bus_m.speed, 250);
        $display("stall seq: recovered speed=%0d", bus_m.speed);

        // period_valid on the very edge the counter would saturate suppresses the stall.
        do_reset();
        pulse(32'd10);
        repeat (STALL - 2) @(negedge clk);
        pulse(32'd10);
        check("race_no_stall", bus_m.stalled, 0);
        check("race_no_pulse", bus_m.speed_valid, 0);
        check("race_speed_kept", bus_m.speed, 100);
        $display("stall race: stalled=%0d", bus_m.stalled);

        // Reset mid-division.
        do_reset();
        pulse(32'd10);
        repeat (9) @(negedge clk);
        do_reset();
        quiet(40, nsv, nbusy);
        check("abort_no_result", nsv, 0);
        check("abort_not_busy", nbusy, 0);
        pulse(32'd25);
        wait_sv(n);
        check("after_abort_latency", n, PW + 1);
        check("after_abort_speed", bus_m.speed, 40);
        $display("abort seq: speed=%0d", bus_m.speed);

`ifdef ENC_SPEED_AVG_EN
        do_reset();
        pulse(32'd10); wait_sv(n); check("avg_speed0", bus_m.speed, 100);
        pulse(32'd10); wait_sv(n); check("avg_speed1", bus_m.speed, 100);
        pulse(32'd10); wait_sv(n); check("avg_speed2", bus_m.speed, 100);
        pulse(32'd50); wait_sv(n); check("avg_speed3", bus_m.speed, 50);
        $display("avg seq: final speed=%0d", bus_m.speed);
`endif

        // Random traffic against the model, in segments of different strobe density.
        rates = '{2, 0, 25, 100, 1, 0, 8, 50};
        @(negedge clk); reset = 1'b1; pv = 1'b0;
        @(posedge clk); model_reset();
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 2400; c++) begin
            int r;
            pv = ($urandom_range(0, 99) < rates[c / 300]);
            r = $urandom_range(0, 9);
            period = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(1, 3)) : 32'($urandom_range(1, 1500));
            @(posedge clk); model_step(pv, period);
            @(negedge clk);
            check("rand_speed",   bus_m.speed, m_speed);
            check("rand_sv",      bus_m.speed_valid, m_sv);
            check("rand_busy",    bus_m.busy, m_job);
            check("rand_stalled", bus_m.stalled, m_stalled);
            check("rand_overrun", bus_m.overrun, m_overrun);
            if (m_sv) $display("rand cycle %0d: speed=%0d stalled=%0d overrun=%0d", c, m_speed, m_stalled, m_overrun);
        end
        pv = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
